// File: rtl/onehot_strobe_decoder_pkg.sv
// Shared definitions for the one-hot strobe decoder: state encoding,
// counter width and the binary-to-one-hot helper.
package onehot_strobe_decoder_pkg;

   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Decode for the default 3-bit code; also used by encoder checkers.
   function automatic logic [7:0] onehot(input logic [2:0] code);
      onehot = 8'd1 << code;
   endfunction

endpackage

// File: rtl/onehot_strobe_decoder_strobe_timer.sv
// Loadable down-counter with a zero flag; paces the HOLD and GAP phases.
module strobe_timer
   import onehot_strobe_decoder_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/onehot_strobe_decoder.sv
// Accepts a binary code and strobes the matching one-hot line for a fixed
// width, then holds all lines low for a gap. ONEHOT_DEC_PARITY_EN adds parity.
module onehot_strobe_decoder
   import onehot_strobe_decoder_pkg::*;
#(
   parameter int N           = 3,
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [N-1:0]      in_code,
`ifdef ONEHOT_DEC_PARITY_EN
   input  logic              in_par,
   output logic              par_err,
`endif
   output logic              in_ready,
   output logic [2**N-1:0]   y,
   output logic              busy,
   output logic              done
);

   localparam int W = 2**N;
   localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

   state_t       state, state_d;
   logic [W-1:0] y_d;
   logic         hold_load, hold_dec, hold_zero;
   logic         gap_load, gap_dec, gap_zero;

`ifdef ONEHOT_DEC_PARITY_EN
   logic code_ok, par_err_d;
   assign code_ok = ~^{in_code, in_par};
`endif

   strobe_timer #(.W(CNT_W)) u_hold_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (hold_load),
      .load_val (HOLD_LD),
      .dec      (hold_dec),
      .zero     (hold_zero)
   );

   strobe_timer #(.W(CNT_W)) u_gap_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (gap_load),
      .load_val (GAP_LD),
      .dec      (gap_dec),
      .zero     (gap_zero)
   );

   always_comb begin
      state_d   = state;
      y_d       = y;
      hold_load = 1'b0;
      hold_dec  = 1'b0;
      gap_load  = 1'b0;
      gap_dec   = 1'b0;
      in_ready  = 1'b0;
      done      = 1'b0;
`ifdef ONEHOT_DEC_PARITY_EN
      par_err_d = 1'b0;
`endif
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
`ifdef ONEHOT_DEC_PARITY_EN
               // Bad parity consumes the code without decoding it.
               if (!code_ok)
                  par_err_d = 1'b1;
               else
`endif
               begin
                  y_d       = W'(1) << in_code;
                  hold_load = 1'b1;
                  state_d   = HOLD;
               end
            end
         end
         HOLD: begin
            if (hold_zero) begin
               done = 1'b1;
               y_d  = '0;
               if (GAP_CYCLES > 0) begin
                  gap_load = 1'b1;
                  state_d  = GAP;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               hold_dec = 1'b1;
            end
         end
         GAP: begin
            if (gap_zero)
               state_d = IDLE;
            else
               gap_dec = 1'b1;
         end
         default: begin
            state_d = IDLE;
            y_d     = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         y     <= '0;
      end else begin
         state <= state_d;
         y     <= y_d;
      end
   end

`ifdef ONEHOT_DEC_PARITY_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         par_err <= 1'b0;
      else
         par_err <= par_err_d;
   end
`endif

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// Self-checking bench for onehot_strobe_decoder: default instance plus a
// HOLD=1/GAP=0 instance; accepted codes go through a scoreboard queue.
module tb_onehot_strobe_decoder;
   import onehot_strobe_decoder_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, busy, done;
   logic [2:0] in_code;
   logic [7:0] y;
   logic       in_valid2, in_ready2, busy2, done2;
   logic [2:0] in_code2;
   logic [7:0] y2;
`ifdef ONEHOT_DEC_PARITY_EN
   logic       in_par, par_err, in_par2, par_err2;
`endif

   int passed = 0;
   int total  = 0;
   logic [2:0] exp_q[$];
   logic [2:0] exp_code;

   always #5 clk = ~clk;

   onehot_strobe_decoder u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_code  (in_code),
`ifdef ONEHOT_DEC_PARITY_EN
      .in_par   (in_par),
      .par_err  (par_err),
`endif
      .in_ready (in_ready),
      .y        (y),
      .busy     (busy),
      .done     (done)
   );

   onehot_strobe_decoder #(.N(3), .HOLD_CYCLES(1), .GAP_CYCLES(0)) u_dut_short (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid2),
      .in_code  (in_code2),
`ifdef ONEHOT_DEC_PARITY_EN
      .in_par   (in_par2),
      .par_err  (par_err2),
`endif
      .in_ready (in_ready2),
      .y        (y2),
      .busy     (busy2),
      .done     (done2)
   );

   // 8-to-3 OR-gate encoder used to recover the code from y.
   function automatic logic [2:0] encode8(input logic [7:0] v);
      encode8[0] = v[1] | v[3] | v[5] | v[7];
      encode8[1] = v[2] | v[3] | v[6] | v[7];
      encode8[2] = v[4] | v[5] | v[6] | v[7];
   endfunction

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; in_code = '0; in_valid2 = 1'b0; in_code2 = '0;
`ifdef ONEHOT_DEC_PARITY_EN
      in_par = 1'b0; in_par2 = 1'b1;
`endif
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      total++; if (y === 8'h00) passed++; else $display("FAIL reset_y got %h exp 00", y);
      total++; if (busy === 1'b0) passed++; else $display("FAIL reset_busy got %b exp 0", busy);
      total++; if (done === 1'b0) passed++; else $display("FAIL reset_done got %b exp 0", done);
      total++; if (in_ready === 1'b1) passed++; else $display("FAIL reset_ready got %b exp 1", in_ready);
      total++; if (y2 === 8'h00 && in_ready2 === 1'b1) passed++;
      else $display("FAIL reset_short got y=%h rdy=%b exp y=00 rdy=1", y2, in_ready2);
`ifdef ONEHOT_DEC_PARITY_EN
      total++; if (par_err === 1'b0) passed++; else $display("FAIL reset_par_err got %b exp 0", par_err);
`endif
   endtask

   task automatic test_single;
      logic [7:0] ey;
      in_valid = 1'b1; in_code = 3'd5; exp_q.push_back(3'd5);
      @(posedge clk);
      #1 in_valid = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         ey = (i <= 4) ? 8'h20 : 8'h00;
         if (i == 1) begin
            exp_code = exp_q.pop_front();
            total++; if (encode8(y) === exp_code) passed++;
            else $display("FAIL single_encode got %0d exp %0d", encode8(y), exp_code);
         end
         total++; if (y === ey) passed++; else $display("FAIL single_y c%0d got %h exp %h", i, y, ey);
         total++; if (done === (i == 4)) passed++; else $display("FAIL single_done c%0d got %b exp %b", i, done, i == 4);
         total++; if (in_ready === (i == 6)) passed++; else $display("FAIL single_ready c%0d got %b exp %b", i, in_ready, i == 6);
         total++; if (busy === (i != 6)) passed++; else $display("FAIL single_busy c%0d got %b exp %b", i, busy, i != 6);
      end
   endtask

   task automatic test_walk;
      logic [7:0] ey;
      in_valid = 1'b1; in_code = 3'd0; exp_q.push_back(3'd0);
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         if (c < 7) begin
            in_code = 3'(c + 1);
            exp_q.push_back(3'(c + 1));
         end else begin
            in_valid = 1'b0;
         end
         for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            ey = (k <= 4) ? onehot(3'(c)) : 8'h00;
            if (k == 1) begin
               exp_code = exp_q.pop_front();
               total++; if (encode8(y) === exp_code) passed++;
               else $display("FAIL walk_encode got %0d exp %0d", encode8(y), exp_code);
            end
            total++; if (y === ey) passed++; else $display("FAIL walk_y code%0d c%0d got %h exp %h", c, k, y, ey);
            total++; if (in_ready === (k == 6)) passed++;
            else $display("FAIL walk_ready code%0d c%0d got %b exp %b", c, k, in_ready, k == 6);
         end
      end
   endtask

   task automatic test_collision;
      logic [7:0] ey;
      in_valid = 1'b1; in_code = 3'd2; exp_q.push_back(3'd2);
      @(posedge clk);
      #1 in_code = 3'd7; exp_q.push_back(3'd7);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         ey = (k <= 4) ? 8'h04 : (k >= 7 && k <= 10) ? 8'h80 : 8'h00;
         if (k == 1 || k == 7) begin
            exp_code = exp_q.pop_front();
            total++; if (encode8(y) === exp_code) passed++;
            else $display("FAIL collide_encode got %0d exp %0d", encode8(y), exp_code);
         end
         total++; if (y === ey) passed++; else $display("FAIL collide_y c%0d got %h exp %h", k, y, ey);
         total++; if ($countones(y) <= 1) passed++; else $display("FAIL collide_onehot c%0d got %h exp <=1 bit", k, y);
         if (k == 7) in_valid = 1'b0;
      end
   endtask

   task automatic test_reset_mid;
      in_valid = 1'b1; in_code = 3'd6; exp_q.push_back(3'd6);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      exp_code = exp_q.pop_front();
      total++; if (y === 8'h40 && encode8(y) === exp_code) passed++;
      else $display("FAIL rmid_y got %h exp 40", y);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      total++; if (done === 1'b0) passed++; else $display("FAIL rmid_done_pre got %b exp 0", done);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      total++; if (y === 8'h00) passed++; else $display("FAIL rmid_y_post got %h exp 00", y);
      total++; if (busy === 1'b0) passed++; else $display("FAIL rmid_busy got %b exp 0", busy);
      total++; if (in_ready === 1'b1) passed++; else $display("FAIL rmid_ready got %b exp 1", in_ready);
      for (int k = 0; k < 4; k++) begin
         total++; if (done === 1'b0 && y === 8'h00) passed++;
         else $display("FAIL rmid_quiet c%0d got done=%b y=%h exp done=0 y=00", k, done, y);
         @(negedge clk);
      end
   endtask

   task automatic test_short;
      logic [7:0] ey;
      in_valid2 = 1'b1; in_code2 = 3'd1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         ey = (k % 2 == 1) ? 8'h02 : 8'h00;
         total++; if (y2 === ey) passed++; else $display("FAIL short_y c%0d got %h exp %h", k, y2, ey);
         total++; if (done2 === (k % 2 == 1)) passed++;
         else $display("FAIL short_done c%0d got %b exp %b", k, done2, k % 2 == 1);
      end
      in_valid2 = 1'b0;
   endtask

`ifdef ONEHOT_DEC_PARITY_EN
   task automatic test_parity;
      in_valid = 1'b1; in_code = 3'd3; in_par = 1'b1;
      @(negedge clk);
      total++; if (par_err === 1'b1) passed++; else $display("FAIL par_err_hi got %b exp 1", par_err);
      total++; if (y === 8'h00 && in_ready === 1'b1) passed++;
      else $display("FAIL par_bad_y got y=%h rdy=%b exp y=00 rdy=1", y, in_ready);
      in_par = 1'b0; exp_q.push_back(3'd3);
      @(negedge clk);
      in_valid = 1'b0;
      exp_code = exp_q.pop_front();
      total++; if (par_err === 1'b0) passed++; else $display("FAIL par_err_lo got %b exp 0", par_err);
      total++; if (y === 8'h08 && encode8(y) === exp_code) passed++; else $display("FAIL par_good_y got %h exp 08", y);
      repeat (6) @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_walk();
      test_collision();
      test_reset_mid();
      test_short();
`ifdef ONEHOT_DEC_PARITY_EN
      test_parity();
`endif
      total++; if (exp_q.size() == 0) passed++;
      else $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size());
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
